// File: rtl/counter_load_pkg.sv
// Shared types for the counter load sink: write-request opcodes and FSM states.
package counter_load_pkg;

  typedef enum logic [1:0] {
    OP_DEPOSIT = 2'b00,
    OP_FORCE   = 2'b01,
    OP_RELEASE = 2'b10,
    OP_RSVD    = 2'b11
  } wr_op_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FORCED = 1'b1
  } state_e;

endpackage

// File: rtl/counter_load_stage.sv
// Single-entry request staging: captures op/data on accept, holds pending for one
// cycle until the sink applies it, and back-pressures the requester meanwhile.
module counter_load_stage
  import counter_load_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid_i,
  input  logic [1:0]       wr_op_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_ready_o,
  output logic             pending_o,
  output logic [1:0]       op_o,
  output logic [WIDTH-1:0] data_o
);

  logic             pend_q, pend_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept;

  assign accept = wr_valid_i && !pend_q;

  // A staged request is always applied on the very next edge, so pending
  // lasts exactly one cycle and can never coincide with a new accept.
  always_comb begin
    pend_d = accept;
    op_d   = op_q;
    data_d = data_q;
    if (accept) begin
      op_d   = wr_op_i;
      data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      op_q   <= OP_DEPOSIT;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      op_q   <= op_d;
      data_q <= data_d;
    end
  end

  assign wr_ready_o = !pend_q;
  assign pending_o  = pend_q;
  assign op_o       = op_q;
  assign data_o     = data_q;

endmodule

// File: rtl/counter_load_sink.sv
// Free-running counter with DEPOSIT/FORCE/RELEASE write port (RUN/FORCED FSM).
// Optional wr_err output enabled by defining COUNTER_LOAD_SINK_ERR_EN.
module counter_load_sink
  import counter_load_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_en,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [1:0]       wr_op,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
`ifdef COUNTER_LOAD_SINK_ERR_EN
  output logic             wr_err,
`endif
  output logic [WIDTH-1:0] counter_value,
  output logic             forced
);

  logic             pending;
  logic [1:0]       stg_op_raw;
  wr_op_e           stg_op;
  logic [WIDTH-1:0] stg_data;

  counter_load_stage #(.WIDTH(WIDTH)) u_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid_i (wr_valid),
    .wr_op_i    (wr_op),
    .wr_data_i  (wr_data),
    .wr_ready_o (wr_ready),
    .pending_o  (pending),
    .op_o       (stg_op_raw),
    .data_o     (stg_data)
  );

  assign stg_op = wr_op_e'(stg_op_raw);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             forced_q;
`ifdef COUNTER_LOAD_SINK_ERR_EN
  logic             err_q, err_d;
`endif

  // Requests with no effect (RELEASE in RUN, reserved op) leave normal
  // counting untouched; only a DEPOSIT in RUN or a FORCE overrides the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
`ifdef COUNTER_LOAD_SINK_ERR_EN
    err_d   = 1'b0;
`endif
    if (state_q == ST_RUN && cnt_en) cnt_d = cnt_q + WIDTH'(1);
    if (pending) begin
      ack_d = 1'b1;
      unique case (stg_op)
        OP_DEPOSIT: begin
          if (state_q == ST_RUN) cnt_d = stg_data;
`ifdef COUNTER_LOAD_SINK_ERR_EN
          else err_d = 1'b1;
`endif
        end
        OP_FORCE: begin
          cnt_d   = stg_data;
          state_d = ST_FORCED;
        end
        OP_RELEASE: begin
          if (state_q == ST_FORCED) state_d = ST_RUN;
        end
        OP_RSVD: begin
`ifdef COUNTER_LOAD_SINK_ERR_EN
          err_d = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      cnt_q    <= RST_VAL;
      ack_q    <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      forced_q <= (state_d == ST_FORCED);
    end
  end

`ifdef COUNTER_LOAD_SINK_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign wr_err = err_q;
`endif

  assign counter_value = cnt_q;
  assign wr_ack        = ack_q;
  assign forced        = forced_q;

endmodule

// File: tb/tb_counter_load_sink.sv
// Bench for counter_load_sink: directed scenarios plus random requests, checked
// against a behavioural model through an ack scoreboard and per-cycle monitor.
module tb_counter_load_sink;
  import counter_load_pkg::*;

  localparam int        WIDTH   = 8;
  localparam logic [7:0] RST_VAL = 8'h00;

  logic       clk, rst_n, cnt_en, wr_valid, wr_ready, wr_ack, forced;
  logic [1:0] wr_op;
  logic [7:0] wr_data, counter_value;
`ifdef COUNTER_LOAD_SINK_ERR_EN
  logic       wr_err;
`endif

  counter_load_sink #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cnt_en        (cnt_en),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_op         (wr_op),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
`ifdef COUNTER_LOAD_SINK_ERR_EN
    .wr_err        (wr_err),
`endif
    .counter_value (counter_value),
    .forced        (forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: timed out", name);
  endtask

  // Behavioural model: counter as an integer mod 256, one stashed request.
  typedef struct {int cnt; bit forced; bit err;} exp_t;
  exp_t ackq[$];
  int   m_cnt    = RST_VAL;
  bit   m_forced = 0;
  bit   m_pend   = 0;
  int   m_op, m_data;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt = RST_VAL; m_forced = 0; m_pend = 0; ackq.delete();
      end else begin
        bit   was_forced, wrote, err;
        exp_t e;
        was_forced = m_forced; wrote = 0; err = 0;
        if (m_pend) begin
          case (m_op)
            0: if (was_forced) err = 1; else begin m_cnt = m_data; wrote = 1; end
            1: begin m_cnt = m_data; m_forced = 1; wrote = 1; end
            2: if (was_forced) m_forced = 0;
            default: err = 1;
          endcase
        end
        if (!wrote && !was_forced && cnt_en) m_cnt = (m_cnt + 1) % 256;
        if (m_pend) begin
          e.cnt = m_cnt; e.forced = m_forced; e.err = err;
          ackq.push_back(e);
          m_pend = 0;
        end else if (wr_valid) begin
          m_pend = 1; m_op = wr_op; m_data = wr_data;
        end
      end
    end
  end

  // Monitor: per-cycle state compare plus ack scoreboard pop.
  initial begin
    forever begin
      @(negedge clk);
      chk("cnt", counter_value, m_cnt);
      chk("forced", forced, m_forced);
      chk("ready", wr_ready, !m_pend);
      if (wr_ack) begin
        if (ackq.size() == 0) begin
          n_chk++;
          $display("FAIL ack_spurious: got ack, expected none");
        end else begin
          exp_t e;
          e = ackq.pop_front();
          chk("ack_cnt", counter_value, e.cnt);
          chk("ack_forced", forced, e.forced);
`ifdef COUNTER_LOAD_SINK_ERR_EN
          chk("ack_err", wr_err, e.err);
`endif
        end
      end else begin
`ifdef COUNTER_LOAD_SINK_ERR_EN
        chk("err_idle", wr_err, 0);
`endif
      end
      chk("ack_missing", ackq.size(), 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Holds wr_valid until the sink is ready; returns just after the accept edge.
  task automatic send(input logic [1:0] op, input logic [7:0] d, input bit keep);
    int t = 0;
    wr_valid = 1'b1; wr_op = op; wr_data = d;
    while (!wr_ready && t < 50) begin tick(1); t++; end
    if (t >= 50) fail_now("send_wait");
    tick(1);
    if (!keep) wr_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cnt_en = 1'b0; wr_valid = 1'b0; wr_op = 2'b00; wr_data = 8'h00;
    tick(2);
    chk("rst_cnt", counter_value, RST_VAL);
    chk("rst_forced", forced, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_ack", wr_ack, 0);

    // Free-run with wrap
    rst_n = 1'b1; cnt_en = 1'b1;
    tick(260);
    chk("wrap_cnt", counter_value, (RST_VAL + 260) % 256);

    // Deposit over a running count
    cnt_en = 1'b0;
    send(OP_DEPOSIT, 8'h10, 0);
    tick(2);
    cnt_en = 1'b1;
    send(OP_DEPOSIT, 8'hA5, 0);
    chk("dep_ready_low", wr_ready, 0);
    tick(1);
    chk("dep_val", counter_value, 8'hA5);
    chk("dep_ack", wr_ack, 1);
    tick(1);
    chk("dep_inc", counter_value, 8'hA6);
    chk("dep_ack_once", wr_ack, 0);

    // Force holds through cnt_en, release resumes
    send(OP_FORCE, 8'h3C, 0);
    tick(20);
    chk("force_hold", counter_value, 8'h3C);
    chk("force_flag", forced, 1);
    send(OP_RELEASE, 8'h00, 0);
    tick(1);
    chk("rel_edge", counter_value, 8'h3C);
    chk("rel_flag", forced, 0);
    tick(1);
    chk("rel_inc", counter_value, 8'h3D);

    // Ignored requests still acked
    cnt_en = 1'b0;
    send(OP_FORCE, 8'h3C, 0);
    tick(1);
    send(OP_DEPOSIT, 8'h77, 0);
    tick(1);
    chk("fdep_val", counter_value, 8'h3C);
    chk("fdep_ack", wr_ack, 1);
`ifdef COUNTER_LOAD_SINK_ERR_EN
    chk("fdep_err", wr_err, 1);
`endif
    send(OP_RELEASE, 8'h00, 0);
    tick(1);
    send(OP_RSVD, 8'hEE, 0);
    tick(1);
    chk("rsvd_val", counter_value, 8'h3C);
    chk("rsvd_ack", wr_ack, 1);
`ifdef COUNTER_LOAD_SINK_ERR_EN
    chk("rsvd_err", wr_err, 1);
`endif

    // Back-to-back requests
    cnt_en = 1'b1;
    send(OP_DEPOSIT, 8'h01, 1);
    send(OP_DEPOSIT, 8'h02, 0);
    tick(1);
    chk("b2b_val", counter_value, 8'h02);
    tick(1);
    chk("b2b_inc", counter_value, 8'h03);

    // Reset while a FORCE is staged
    send(OP_FORCE, 8'h55, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_cnt", counter_value, RST_VAL);
    chk("mrst_forced", forced, 0);
    tick(1);
    chk("mrst_noack", wr_ack, 0);
    rst_n = 1'b1;
    tick(3);
    chk("mrst_resume", counter_value, (RST_VAL + 3) % 256);

    // Random traffic
    repeat (200) begin
      cnt_en = 1'($urandom);
      tick($urandom_range(0, 4));
      if ($urandom_range(0, 40) == 0) begin
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
      end
      send(2'($urandom), 8'($urandom), 0);
    end
    wr_valid = 1'b0;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_load_sink.md
COUNTER_LOAD_SINK -- requirements
Module: counter_load_sink

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and data width.
REQ-002 SHALL have parameter RST_VAL, default 0, counter value at reset.
REQ-003 SHALL have clk  input  1  clock, rising-edge; reset rst_n, asynchronous, active-low; clock clk.
REQ-004 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have cnt_en  input  1  increment enable in RUN state.
REQ-006 SHALL have wr_valid  input  1  write request valid, driven down from upper hierarchy.
REQ-007 SHALL have wr_ready  output  1  sink can accept a request.
REQ-008 SHALL have wr_op  input  2  operation: 00 DEPOSIT, 01 FORCE, 10 RELEASE, 11 reserved.
REQ-009 SHALL have wr_data  input  WIDTH  operand for DEPOSIT/FORCE.
REQ-010 SHALL have wr_ack  output  1  one-cycle pulse: request applied.
REQ-011 SHALL have counter_value  output  WIDTH  current counter value, read upward.
REQ-012 SHALL have forced  output  1  high while in FORCED state.

Function
REQ-013 SHALL accept a request on a rising edge where wr_valid && wr_ready, capturing wr_op/wr_data into a staging register and setting pending.
REQ-014 SHALL drive wr_ready = !pending; single outstanding request, max one accept per 2 cycles.
REQ-015 SHALL apply a staged request on the edge after acceptance; new value visible on counter_value and wr_ack high for exactly the following cycle; pending cleared on the same edge.
REQ-016 SHALL implement states RUN and FORCED; reset state RUN.
REQ-017 RUN, no applied request: counter_value += 1 when cnt_en, modulo 2^WIDTH (all-ones wraps to 0, no flag); holds otherwise.
REQ-018 RUN + DEPOSIT: counter_value := wr_data; deposit wins over increment on that edge; stay RUN; counting resumes next edge.
REQ-019 RUN + FORCE: counter_value := wr_data; go FORCED.
REQ-020 FORCED: counter_value held, cnt_en ignored.
REQ-021 FORCED + FORCE: counter_value := new wr_data; stay FORCED.
REQ-022 FORCED + RELEASE: go RUN, value unchanged on release edge; increments from held value on subsequent edges.
REQ-023 FORCED + DEPOSIT: no effect on value or state; still acked.
REQ-024 RUN + RELEASE and any reserved op (11): no effect; still acked.
REQ-025 forced SHALL be a registered decode of state (high the cycle after the FORCE apply edge).
REQ-026 wr_valid while wr_ready low SHALL be ignored; the requester holds it until accepted.

Reset
REQ-027 Asserting rst_n low SHALL immediately set counter_value=RST_VAL, state=RUN, forced=0, pending=0, wr_ready=1, wr_ack=0, wr_err=0.
REQ-028 Reset mid-operation SHALL discard any staged request with no wr_ack; first acceptance possible on the first rising edge after deassertion.

Configuration
REQ-029 Macro COUNTER_LOAD_SINK_ERR_EN defined: adds output wr_err (1 bit), pulsing with wr_ack for reserved ops and DEPOSIT-in-FORCED; both still acked with no effect.
REQ-030 Macro undefined: no wr_err port, no error logic; those requests are acked silently.

Structure
REQ-031 Package counter_load_pkg SHALL hold the wr_op enum (OP_DEPOSIT, OP_FORCE, OP_RELEASE, OP_RSVD) and state enum (ST_RUN, ST_FORCED).
REQ-032 Sub-module counter_load_stage SHALL implement the staging register, pending flag and wr_ready; the FSM and counter stay in counter_load_sink.

Verification
REQ-033 Reset, cnt_en=1 for 260 cycles -> counter_value 0,1,...,255,0,1,2,3; wr_ready=1, forced=0 throughout.
REQ-034 Counter at 0x10 counting, DEPOSIT 0xA5 accepted at edge N -> wr_ready=0 in cycle N; edge N+1: counter_value=0xA5, wr_ack=1 one cycle; edge N+2: 0xA6.
REQ-035 FORCE 0x3C, then 20 cycles cnt_en=1 -> counter_value stays 0x3C, forced=1; RELEASE -> 0x3C on release edge, 0x3D next edge, forced=0.
REQ-036 In FORCED 0x3C: DEPOSIT 0x77 -> value 0x3C, wr_ack=1, wr_err=1 (macro on); op 11 in RUN -> no change, wr_ack=1, wr_err=1.
REQ-037 Back-to-back wr_valid=1 with DEPOSIT 0x01, 0x02 -> accepts spaced 2 cycles, two wr_ack pulses, final value 0x02 then increments.
REQ-038 rst_n low the cycle after accepting FORCE 0x55 -> counter_value=RST_VAL, forced=0, no wr_ack; counting resumes after deassertion.
